// File: rtl/add_arb_pkg.sv
// Shared types and constants for the round-robin adder arbiter.
package add_arb_pkg;

    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] SAT_POS = 32'h7FFF_FFFF;
    localparam logic [DATA_W-1:0] SAT_NEG = 32'h8000_0000;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder.sv
// 32-bit two-level carry look-ahead adder (4-bit groups).
module adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;
    logic [7:0]  gg;
    logic [7:0]  gp;
    logic [8:0]  gc;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        for (int k = 0; k < 8; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
        gc[0] = cin;
        for (int k = 0; k < 8; k++) begin
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end
        // In-group carries come straight from the group carry-in.
        for (int k = 0; k < 8; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1]
                     | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2]
                     | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end
        c[32] = gc[8];
    end

    assign sum  = p ^ c[31:0];
    assign cout = c[32];

endmodule

// File: rtl/rr_arbiter.sv
// Generic N-way round-robin picker: first valid at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int off = 0; off < N; off++) begin
            j = (int'(ptr) + off) % N;
            if (!any && valid[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Shares one 32-bit adder among N_REQ requesters with round-robin grant.
// Define ADD_ARB_SAT_EN to saturate res_sum on signed overflow.
module adder_rr_arbiter
    import add_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_x,
    input  logic [N_REQ*DATA_W-1:0] req_y,
    input  logic [N_REQ-1:0]        req_cin,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [ID_W-1:0]         res_id,
    output logic [DATA_W-1:0]       res_sum,
    output logic                    res_cout,
    output logic                    res_ovf
);

    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   gnt_idx;
    logic              gnt_any;
    logic              can_accept;
    logic              accept;

    logic [DATA_W-1:0] op_x;
    logic [DATA_W-1:0] op_y;
    logic              op_cin;
    logic [DATA_W-1:0] raw_sum;
    logic              raw_cout;
    logic              ovf;
    logic [DATA_W-1:0] fin_sum;

    out_state_t        state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   res_id_q, res_id_d;
    logic [DATA_W-1:0] res_sum_q, res_sum_d;
    logic              res_cout_q, res_cout_d;
    logic              res_ovf_q, res_ovf_d;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (ID_W)
    ) u_rr (
        .valid (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    assign can_accept = (state_q == EMPTY) || res_ready;
    assign req_ready  = grant & {N_REQ{can_accept}};
    assign accept     = gnt_any && can_accept;

    always_comb begin
        op_x   = '0;
        op_y   = '0;
        op_cin = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                op_x   = req_x[DATA_W*i +: DATA_W];
                op_y   = req_y[DATA_W*i +: DATA_W];
                op_cin = req_cin[i];
            end
        end
    end

    adder u_adder (
        .a    (op_x),
        .b    (op_y),
        .cin  (op_cin),
        .sum  (raw_sum),
        .cout (raw_cout)
    );

    assign ovf = (op_x[31] == op_y[31]) && (raw_sum[31] != op_x[31]);

`ifdef ADD_ARB_SAT_EN
    assign fin_sum = !ovf ? raw_sum : (op_x[31] ? SAT_NEG : SAT_POS);
`else
    assign fin_sum = raw_sum;
`endif

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        res_id_d   = res_id_q;
        res_sum_d  = res_sum_q;
        res_cout_d = res_cout_q;
        res_ovf_d  = res_ovf_q;
        unique case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL:  if (res_ready && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (accept) begin
            res_id_d   = gnt_idx;
            res_sum_d  = fin_sum;
            res_cout_d = raw_cout;
            res_ovf_d  = ovf;
            if (int'(gnt_idx) == N_REQ - 1) rr_ptr_d = '0;
            else rr_ptr_d = gnt_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            rr_ptr_q   <= '0;
            res_id_q   <= '0;
            res_sum_q  <= '0;
            res_cout_q <= 1'b0;
            res_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            res_id_q   <= res_id_d;
            res_sum_q  <= res_sum_d;
            res_cout_q <= res_cout_d;
            res_ovf_q  <= res_ovf_d;
        end
    end

    assign res_valid = (state_q == FULL);
    assign res_id    = res_id_q;
    assign res_sum   = res_sum_q;
    assign res_cout  = res_cout_q;
    assign res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Self-checking bench for adder_rr_arbiter: vector table, corner sequences, random vs model.
module tb_adder_rr_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_x;
    logic [N*32-1:0] req_y;
    logic [N-1:0]    req_cin;
    logic            res_valid;
    logic            res_ready;
    logic [1:0]      res_id;
    logic [31:0]     res_sum;
    logic            res_cout;
    logic            res_ovf;

    int checks = 0;
    int errors = 0;

    adder_rr_arbiter #(.N_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_cin   (req_cin),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_ovf   (res_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] x;
        logic [31:0] y;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] x, input logic [31:0] y, input logic c);
        req_x[32*i +: 32] = x;
        req_y[32*i +: 32] = y;
        req_cin[i]        = c;
    endtask

    // Reference arithmetic from integer values: returns {ovf, cout, sum}.
    function automatic logic [33:0] ref_add(input logic [31:0] x, input logic [31:0] y, input logic c);
        longint u;
        longint s;
        logic   o;
        logic [31:0] r;
        u = longint'({32'd0, x}) + longint'({32'd0, y}) + longint'(c);
        s = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        r = u[31:0];
`ifdef ADD_ARB_SAT_EN
        if (o) r = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        return {o, u[32], r};
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    vec_t vt[7];

    bit          pend[N];
    logic [31:0] px[N];
    logic [31:0] py[N];
    logic        pc[N];
    int          mptr;
    bit          mfull;
    logic [33:0] mres;
    int          mid;

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        req_cin   = '0;
        res_ready = 1'b0;
        #3;
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_sum", 64'(res_sum), 64'd0);
        chk("rst_id", 64'(res_id), 64'd0);
        chk("rst_cout", 64'(res_cout), 64'd0);
        chk("rst_ovf", 64'(res_ovf), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("idle_ready", 64'(req_ready), 64'd0);
        chk("idle_valid", 64'(res_valid), 64'd0);

        // Fairness: all requesters valid, downstream always ready.
        for (int i = 0; i < N; i++) set_op(i, 32'(100 * i), 32'd1, 1'b0);
        req_valid = '1;
        res_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("fair_ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
            step();
            chk("fair_id", 64'(res_id), 64'(k % 4));
            chk("fair_sum", 64'(res_sum), 64'(100 * (k % 4) + 1));
            chk("fair_valid", 64'(res_valid), 64'd1);
        end
        req_valid = '0;
        step();
        chk("fair_drain", 64'(res_valid), 64'd0);

        vt[0] = '{0, 32'd5, 32'd7, 1'b1, 32'd13, 1'b0, 1'b0};
        vt[1] = '{1, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1, 1'b0};
`ifdef ADD_ARB_SAT_EN
        vt[2] = '{2, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
        vt[3] = '{3, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1, 1'b1};
`else
        vt[2] = '{2, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vt[3] = '{3, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
`endif
        vt[4] = '{0, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
        vt[5] = '{2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vt[6] = '{1, 32'd0, 32'd0, 1'b1, 32'd1, 1'b0, 1'b0};

        for (int v = 0; v < 7; v++) begin
            set_op(vt[v].idx, vt[v].x, vt[v].y, vt[v].cin);
            req_valid = N'(1) << vt[v].idx;
            step();
            req_valid = '0;
            chk("vec_valid", 64'(res_valid), 64'd1);
            chk("vec_id", 64'(res_id), 64'(vt[v].idx));
            chk("vec_sum", 64'(res_sum), 64'(vt[v].sum));
            chk("vec_cout", 64'(res_cout), 64'(vt[v].cout));
            chk("vec_ovf", 64'(res_ovf), 64'(vt[v].ovf));
        end
        step();
        chk("vec_drain", 64'(res_valid), 64'd0);

        // Back-pressure: hold FULL for 5 cycles, then drain and refill together.
        res_ready = 1'b0;
        set_op(0, 32'd10, 32'd20, 1'b0);
        req_valid = 4'b0001;
        step();
        set_op(1, 32'd3, 32'd4, 1'b0);
        req_valid = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_ready", 64'(req_ready), 64'd0);
            chk("bp_valid", 64'(res_valid), 64'd1);
            chk("bp_sum", 64'(res_sum), 64'd30);
            chk("bp_id", 64'(res_id), 64'd0);
            step();
        end
        res_ready = 1'b1;
        #1;
        chk("bp_rel_ready", 64'(req_ready), 64'b0010);
        step();
        req_valid = '0;
        chk("bp_refill_valid", 64'(res_valid), 64'd1);
        chk("bp_refill_sum", 64'(res_sum), 64'd7);
        chk("bp_refill_id", 64'(res_id), 64'd1);
        step();
        chk("bp_drain", 64'(res_valid), 64'd0);

        // Reset while FULL: result discarded immediately, pointer back to 0.
        res_ready = 1'b0;
        set_op(2, 32'd1, 32'd1, 1'b0);
        req_valid = 4'b0100;
        step();
        chk("rs_full", 64'(res_valid), 64'd1);
        set_op(1, 32'd40, 32'd2, 1'b0);
        set_op(3, 32'd50, 32'd2, 1'b0);
        req_valid = 4'b1010;
        rst = 1'b1;
        #1;
        chk("rs_valid", 64'(res_valid), 64'd0);
        chk("rs_sum", 64'(res_sum), 64'd0);
        rst = 1'b0;
        #1;
        chk("rs_ready", 64'(req_ready), 64'b0010);
        step();
        chk("rs_id", 64'(res_id), 64'd1);
        chk("rs_sum2", 64'(res_sum), 64'd42);
        req_valid = '0;
        res_ready = 1'b1;
        step();

        // Random traffic against the reference model, from a clean reset.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        mptr  = 0;
        mfull = 1'b0;
        mres  = '0;
        mid   = 0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            int g;
            bit can;
            logic [N-1:0] exp_rdy;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    px[i] = rnd32();
                    py[i] = rnd32();
                    pc[i] = 1'($urandom_range(0, 1));
                end
                req_valid[i] = pend[i];
                if (pend[i]) set_op(i, px[i], py[i], pc[i]);
            end
            res_ready = ($urandom_range(0, 3) != 0);
            can = !mfull || res_ready;
            g = -1;
            for (int off = 0; off < N; off++) begin
                if (g < 0 && pend[(mptr + off) % N]) g = (mptr + off) % N;
            end
            exp_rdy = (g >= 0 && can) ? (N'(1) << g) : '0;
            #1;
            chk("rnd_ready", 64'(req_ready), 64'(exp_rdy));
            step();
            if (g >= 0 && can) begin
                mfull   = 1'b1;
                mres    = ref_add(px[g], py[g], pc[g]);
                mid     = g;
                mptr    = (g + 1) % N;
                pend[g] = 1'b0;
            end else if (mfull && res_ready) begin
                mfull = 1'b0;
            end
            chk("rnd_valid", 64'(res_valid), 64'(mfull));
            if (mfull) begin
                chk("rnd_id", 64'(res_id), 64'(mid));
                chk("rnd_sum", 64'(res_sum), 64'(mres[31:0]));
                chk("rnd_cout", 64'(res_cout), 64'(mres[32]));
                chk("rnd_ovf", 64'(res_ovf), 64'(mres[33]));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
